// File: rtl/fill_pkg.sv
// Shared encodings for the rectangle fill engine: pattern modes, FSM states and
// 3-bit RGB colour constants for the VGA adapter.
package fill_pkg;

    localparam logic [1:0] MODE_SOLID     = 2'b00;
    localparam logic [1:0] MODE_COLSTRIPE = 2'b01;
    localparam logic [1:0] MODE_ROWSTRIPE = 2'b10;
    localparam logic [1:0] MODE_CHECKER   = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StDraw = 2'b01,
        StDone = 2'b10
    } fill_state_e;

    // {R, G, B}
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

endpackage

// File: rtl/rect_scan_counter.sv
// Raster scan counter for the fill engine: xc runs fastest over 0..w-1, then yc over 0..h-1.
// Exposes the post-advance values so the top can register the upcoming pixel.
module rect_scan_counter #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          advance,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    output logic [XW-1:0] xc_next,
    output logic [YW-1:0] yc_next,
    output logic          last
);

    localparam logic [XW-1:0] XOne = 1;
    localparam logic [YW-1:0] YOne = 1;

    logic [XW-1:0] xc_q;
    logic [YW-1:0] yc_q;
    logic          row_end;

    always_comb begin
        row_end = (xc_q == w - XOne);
        xc_next = row_end ? '0 : xc_q + XOne;
        yc_next = row_end ? yc_q + YOne : yc_q;
        last    = row_end && (yc_q == h - YOne);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xc_q <= '0;
            yc_q <= '0;
        end else if (init) begin
            xc_q <= '0;
            yc_q <= '0;
        end else if (advance) begin
            xc_q <= xc_next;
            yc_q <= yc_next;
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: one registered pixel per clock in raster order with four colour
// patterns. Define RECT_FILL_CLIP_EN to suppress plot for pixels outside the visible screen.
module rect_fill_engine
    import fill_pkg::*;
#(
    parameter int unsigned XW            = 8,
    parameter int unsigned YW            = 7,
    parameter int unsigned CW            = 3,
    parameter int unsigned SCREEN_WIDTH  = 160,
    parameter int unsigned SCREEN_HEIGHT = 120
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour_in,
    input  logic [1:0]    mode,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

`ifdef RECT_FILL_CLIP_EN
    localparam bit ClipEn = 1'b1;
`else
    localparam bit ClipEn = 1'b0;
`endif

    localparam logic [XW:0] XLimit = SCREEN_WIDTH[XW:0];
    localparam logic [YW:0] YLimit = SCREEN_HEIGHT[YW:0];

    fill_state_e state_q, state_d;

    logic [XW-1:0] x0_q, w_q;
    logic [YW-1:0] y0_q, h_q;
    logic [CW-1:0] base_q;
    logic [1:0]    mode_q;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] colour_q;
    logic          plot_q, busy_q, done_q;

    logic          latch_cmd, load_pix, cnt_init, cnt_advance;
    logic [XW-1:0] xc_next;
    logic [YW-1:0] yc_next;
    logic          last;

    logic [XW-1:0] src_x0, src_xc;
    logic [YW-1:0] src_y0, src_yc;
    logic [CW-1:0] src_base;
    logic [1:0]    src_mode;

    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_colour;
    logic          pix_vis;

    rect_scan_counter #(
        .XW (XW),
        .YW (YW)
    ) u_scan (
        .clk     (clk),
        .reset   (resetb),
        .init    (cnt_init),
        .advance (cnt_advance),
        .w       (w_q),
        .h       (h_q),
        .xc_next (xc_next),
        .yc_next (yc_next),
        .last    (last)
    );

    // Pixel source is the live inputs on the accepting cycle so the first pixel can be
    // registered in the same edge that samples start.
    always_comb begin
        state_d     = state_q;
        latch_cmd   = 1'b0;
        load_pix    = 1'b0;
        cnt_init    = 1'b0;
        cnt_advance = 1'b0;
        src_x0      = x0_q;
        src_y0      = y0_q;
        src_base    = base_q;
        src_mode    = mode_q;
        src_xc      = xc_next;
        src_yc      = yc_next;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch_cmd = 1'b1;
                    cnt_init  = 1'b1;
                    if (w != '0 && h != '0) begin
                        state_d  = StDraw;
                        load_pix = 1'b1;
                        src_x0   = x0;
                        src_y0   = y0;
                        src_base = colour_in;
                        src_mode = mode;
                        src_xc   = '0;
                        src_yc   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDraw: begin
                if (last) begin
                    state_d = StDone;
                end else begin
                    load_pix    = 1'b1;
                    cnt_advance = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pix_x      = src_x0 + src_xc;
        pix_y      = src_y0 + src_yc;
        pix_colour = src_base;
        unique case (src_mode)
            MODE_SOLID:     pix_colour = src_base;
            MODE_COLSTRIPE: pix_colour = src_base + src_xc[CW-1:0];
            MODE_ROWSTRIPE: pix_colour = src_base + src_yc[CW-1:0];
            MODE_CHECKER:   pix_colour = (src_xc[0] ^ src_yc[0]) ? ~src_base : src_base;
            default:        pix_colour = src_base;
        endcase
        // Unwrapped sums so coordinates past 2^XW / 2^YW still count as off-screen.
        pix_vis = !ClipEn ||
                  ((({1'b0, src_x0} + {1'b0, src_xc}) < XLimit) &&
                   (({1'b0, src_y0} + {1'b0, src_yc}) < YLimit));
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q  <= StIdle;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            base_q   <= '0;
            mode_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_cmd) begin
                x0_q   <= x0;
                y0_q   <= y0;
                w_q    <= w;
                h_q    <= h;
                base_q <= colour_in;
                mode_q <= mode;
            end
            if (load_pix) begin
                x_q      <= pix_x;
                y_q      <= pix_y;
                colour_q <= pix_colour;
            end
            plot_q <= load_pix && pix_vis;
            busy_q <= (state_d != StIdle);
            done_q <= (state_d == StDone);
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed and random commands checked cycle by cycle against
// an index-based raster model. Honours RECT_FILL_CLIP_EN the same way as the design.
module tb_rect_fill_engine;
    import fill_pkg::*;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

`ifdef RECT_FILL_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetb, start;
    logic [XW-1:0] x0, w;
    logic [YW-1:0] y0, h;
    logic [CW-1:0] colour_in;
    logic [1:0]    mode;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    rect_fill_engine dut (
        .clk       (clk),
        .resetb    (resetb),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .colour_in (colour_in),
        .mode      (mode),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_colour(int base, int m, int xc, int yc);
        case (m)
            0:       return base;
            1:       return (base + xc) % 8;
            2:       return (base + yc) % 8;
            default: return (((xc ^ yc) & 1) != 0) ? (7 - base) : base;
        endcase
    endfunction

    task automatic scramble_inputs();
        x0        = XW'($urandom);
        y0        = YW'($urandom);
        w         = XW'($urandom);
        h         = YW'($urandom);
        colour_in = CW'($urandom);
        mode      = 2'($urandom);
    endtask

    // Called at #1 into an IDLE cycle; returns at #1 into the following IDLE cycle.
    task automatic run_cmd(input int ax0, input int ay0, input int aw, input int ah,
                           input int ac, input int am, input bit disturb);
        int n, exp_plots, got_plots, xc, yc, ep;
        x0 = XW'(ax0); y0 = YW'(ay0); w = XW'(aw); h = YW'(ah);
        colour_in = CW'(ac); mode = 2'(am);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = aw * ah;
        exp_plots = 0;
        got_plots = 0;
        for (int k = 0; k < n; k++) begin
            xc = k % aw;
            yc = k / aw;
            ep = (!CLIP || ((ax0 + xc) < 160 && (ay0 + yc) < 120)) ? 1 : 0;
            exp_plots += ep;
            got_plots += int'(plot);
            check_eq("x", 32'(x), 32'((ax0 + xc) % 256));
            check_eq("y", 32'(y), 32'((ay0 + yc) % 128));
            check_eq("colour", 32'(colour), 32'(model_colour(ac, am, xc, yc)));
            check_eq("plot", 32'(plot), 32'(ep));
            check_eq("busy_draw", 32'(busy), 32'd1);
            check_eq("done_draw", 32'(done), 32'd0);
            if (disturb) begin
                scramble_inputs();
                start = 1'($urandom);
            end
            tick();
        end
        check_eq("plot_count", 32'(got_plots), 32'(exp_plots));
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_done", 32'(busy), 32'd1);
        check_eq("plot_done", 32'(plot), 32'd0);
        if (disturb) start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("done_idle", 32'(done), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("plot_idle", 32'(plot), 32'd0);
    endtask

    initial begin
        resetb = 1'b1;
        start  = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0; mode = '0;
        tick();
        tick();
        check_eq("rst_x", 32'(x), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_colour", 32'(colour), 32'd0);
        check_eq("rst_plot", 32'(plot), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        resetb = 1'b0;
        tick();

        run_cmd(0, 0, 160, 120, int'(RED), int'(MODE_SOLID), 1'b0);
        run_cmd(10, 5, 4, 2, int'(BLACK), int'(MODE_COLSTRIPE), 1'b0);
        run_cmd(10, 5, 4, 2, int'(BLUE), int'(MODE_CHECKER), 1'b0);
        run_cmd(3, 9, 5, 3, int'(GREEN), int'(MODE_ROWSTRIPE), 1'b0);
        run_cmd(0, 0, 0, 7, int'(WHITE), int'(MODE_SOLID), 1'b0);
        run_cmd(20, 20, 6, 0, int'(WHITE), int'(MODE_SOLID), 1'b0);
        run_cmd(158, 119, 4, 2, int'(YELLOW), int'(MODE_COLSTRIPE), 1'b0);
        run_cmd(250, 126, 9, 4, int'(RED), int'(MODE_CHECKER), 1'b1);

        // Abort mid-fill: outputs clear next cycle and no done pulse follows.
        x0 = 8'd3; y0 = 7'd3; w = 8'd10; h = 7'd10; colour_in = RED; mode = MODE_SOLID;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("mid_busy", 32'(busy), 32'd1);
        resetb = 1'b1;
        tick();
        resetb = 1'b0;
        check_eq("abort_plot", 32'(plot), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_x", 32'(x), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_abort_done", 32'(done), 32'd0);
            check_eq("post_abort_plot", 32'(plot), 32'd0);
        end
        run_cmd(1, 2, 3, 3, int'(GREEN), int'(MODE_CHECKER), 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
